data_memory_pipe: RTL
=====================

Name: data_memory_pipe

Overview:
Parametrised successor to the CPU's single-port data memory. Synchronous, byte-addressed, with sub-word loads/stores and sign/zero extension. Uses a valid/ready request port and a fixed-latency, in-order response pipeline. An init FSM zeroes the array after reset, and misaligned or out-of-range accesses are flagged. Sits between the load/store unit and the memory array.

Parameters:
DATA_W, 32, data word width in bits; legal values 32 or 64.
DEPTH, 256, number of DATA_W words; power of two, at least 4.
ADDR_W, 32, request byte-address width.
READ_LAT, 1, cycles from request accept to resp_valid; legal range 1..4.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W = 64).
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_wdata  in  DATA_W  store data, LSB-aligned.
resp_valid  out  1  response strobe, exactly one per accepted request.
resp_write  out  1  echoes req_write of the responding request.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_err  out  1  access was misaligned, out of range or an illegal size.
init_done  out  1  array clear complete.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - req_ready, resp_valid, resp_write, resp_err and init_done go to 0; resp_rdata goes to 0.
  - The response pipeline is flushed and the FSM enters INIT with clear index 0.
- FSM state INIT:
  - Writes 0 to word[idx] each cycle; idx counts 0..DEPTH-1.
  - Moves to RUN after the word[DEPTH-1] write, so the sweep takes DEPTH cycles.
  - req_ready = 0 throughout.
- FSM state RUN:
  - req_ready = 1 and init_done = 1.
  - No exit except reset.
- Reset mid-sweep or mid-request restarts INIT from idx 0. In-flight responses are discarded and never emitted.
- Accept: a request is accepted on a cycle where req_valid and req_ready are both 1. One request can be accepted per cycle.
- Address decode, with BYTES = DATA_W/8:
  - word index = req_addr / BYTES.
  - byte offset = req_addr mod BYTES.
- Error cases (set resp_err):
  - Misaligned: byte offset not a multiple of 2^req_size.
  - Out of range: word index >= DEPTH.
  - Illegal size: req_size = 3 with DATA_W = 32.
  - Errored stores do not modify memory. Errored loads return rdata 0.
- Stores:
  - Only the addressed bytes, taken from the low bytes of req_wdata, are written, at the accept edge.
  - The array is updated at that same edge.
- Loads:
  - The array is read at the accept edge.
  - The selected bytes are right-shifted to the LSB, then sign- or zero-extended to DATA_W.
- Response timing:
  - Every accepted request, load, store or errored, produces resp_valid exactly READ_LAT cycles after acceptance.
  - Responses are in order. There is no response back-pressure.
  - resp_valid is a one-cycle strobe per request. Back-to-back requests give back-to-back strobes.
- Read-after-write: a load accepted the cycle after a store to the same word sees the new data. There is no bypass hazard because there is one port and the write commits at the accept edge.
- Addressing: no wrap-around; high address bits beyond DEPTH produce an error, not aliasing.
- Latency pipeline: READ_LAT-1 register stages after the read register.

Decomposition:
- Shared package mem_pkg holds:
  - size codes SZ_BYTE / SZ_HALF / SZ_WORD / SZ_DWORD;
  - the FSM state enum (ST_INIT, ST_RUN);
  - the function clog2.
- One natural sub-module, load_align, a combinational helper: byte offset, size, unsigned flag and raw word in; extended data out.
- The array, FSM and latency pipeline stay in data_memory_pipe.

Test Plan:
- Init: release rst_n with DEPTH = 256 -> req_ready stays 0 for 256 cycles, then 1 with init_done = 1. A load of 0x3FC then returns 0x00000000.
- Store/load: store word 0xDEADBEEF at 0x10, then load byte at 0x13 signed and unsigned -> 0xFFFFFFDE and 0x000000DE. A half load at 0x10 signed -> 0xFFFFBEEF.
- Partial store: word 0x11223344 at 0x20, then byte store 0xAA at 0x21 -> word load at 0x20 returns 0x1122AA44.
- Errors:
  - Half load at 0x01 -> resp_err = 1, rdata 0.
  - Word store at 0x400 with DEPTH = 256 -> resp_err = 1 and memory unchanged.
  - size 3 with DATA_W = 32 -> resp_err = 1.
- Latency/back-to-back: READ_LAT = 3 with 4 consecutive accepts -> 4 consecutive resp_valid strobes starting 3 cycles after the first accept, in order, with resp_write echoed.
- Reset mid-flight: assert rst_n low between accept and response -> no resp_valid is emitted, and a new INIT sweep clears previously written data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the pipelined data memory: access size codes,
// controller state encoding and a constant-width helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: shifts the addressed bytes of a raw array word down to
// the LSB and sign- or zero-extends them to the full data width.
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] raw_word,
  output logic [DATA_W-1:0] ext_data
);

  logic [DATA_W-1:0] shifted_s;
  int                nbits_s;
  logic              sign_s;

  // Shift selected bytes to bit 0, then fill everything above the access width
  always_comb begin
    shifted_s = raw_word >> {byte_off, 3'b000};
    nbits_s   = DATA_W;
    sign_s    = 1'b0;
    ext_data  = '0;
    case (size)
      SZ_BYTE: begin
        nbits_s = 32'd8;
        sign_s  = shifted_s[7];
      end
      SZ_HALF: begin
        nbits_s = 32'd16;
        sign_s  = shifted_s[15];
      end
      SZ_WORD: begin
        nbits_s = 32'd32;
        sign_s  = shifted_s[31];
      end
      default: begin
        nbits_s = DATA_W;
        sign_s  = shifted_s[DATA_W-1];
      end
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits_s) begin
        ext_data[i] = shifted_s[i];
      end else begin
        ext_data[i] = sign_s & ~is_unsigned;
      end
    end
  end

endmodule

// File: rtl/data_memory_pipe.sv
// Byte-addressed single-port data memory with valid/ready requests, a
// fixed-latency in-order response pipeline and a post-reset clearing sweep.
module data_memory_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = clog2(BYTES);
  localparam int IDX_W = clog2(DEPTH);

  state_e            state_r, state_n_s;
  logic [IDX_W-1:0]  idx_r, idx_n_s;
  logic              ready_r, done_r;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [OFF_W-1:0]  off_s;
  logic [OFF_W-1:0]  amask_s;
  logic [IDX_W-1:0]  widx_s;
  logic              mis_s, oor_s, ill_s, err_s;
  logic              acc_s, wr_en_s;
  logic [DATA_W-1:0] rd_word_s, ext_s, wd_shift_s, merge_s;
  int                nbytes_s;

  logic [READ_LAT-1:0] pv_r, pw_r, pe_r;
  logic [DATA_W-1:0]   pd_r [READ_LAT];

  // Controller state, clear index and the registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
      idx_r   <= '0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      idx_r   <= idx_n_s;
      ready_r <= (state_n_s == ST_RUN);
      done_r  <= (state_n_s == ST_RUN);
    end
  end

  // Next-state logic: sweep every word once, then serve requests forever
  always_comb begin
    state_n_s = state_r;
    idx_n_s   = idx_r;
    case (state_r)
      ST_INIT: begin
        if (idx_r == IDX_W'(DEPTH - 1)) begin
          state_n_s = ST_RUN;
          idx_n_s   = '0;
        end else begin
          idx_n_s = idx_r + IDX_W'(1);
        end
      end
      ST_RUN: begin
        state_n_s = ST_RUN;
      end
      default: begin
        state_n_s = ST_INIT;
        idx_n_s   = '0;
      end
    endcase
  end

  // Request decode: split address, classify errors, build the store merge
  always_comb begin
    off_s  = req_addr[OFF_W-1:0];
    widx_s = req_addr[OFF_W+IDX_W-1:OFF_W];
    oor_s  = |req_addr[ADDR_W-1:OFF_W+IDX_W];
    case (req_size)
      SZ_BYTE: begin
        amask_s  = '0;
        nbytes_s = 32'd1;
      end
      SZ_HALF: begin
        amask_s  = OFF_W'(3'd1);
        nbytes_s = 32'd2;
      end
      SZ_WORD: begin
        amask_s  = OFF_W'(3'd3);
        nbytes_s = 32'd4;
      end
      default: begin
        amask_s  = OFF_W'(3'd7);
        nbytes_s = 32'd8;
      end
    endcase
    mis_s      = |(off_s & amask_s);
    ill_s      = (req_size == SZ_DWORD) && (DATA_W < 64);
    err_s      = mis_s | oor_s | ill_s;
    acc_s      = req_valid & ready_r;
    wr_en_s    = acc_s & req_write & ~err_s;
    rd_word_s  = mem_r[widx_s];
    wd_shift_s = req_wdata << {off_s, 3'b000};
    merge_s    = rd_word_s;
    for (int b = 0; b < BYTES; b++) begin
      if ((b >= int'(off_s)) && (b < int'(off_s) + nbytes_s)) begin
        merge_s[b*8 +: 8] = wd_shift_s[b*8 +: 8];
      end else begin
        merge_s[b*8 +: 8] = rd_word_s[b*8 +: 8];
      end
    end
  end

  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .byte_off    (off_s),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .raw_word    (rd_word_s),
    .ext_data    (ext_s)
  );

  // Array write port; the array itself carries no reset, the sweep clears it
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[idx_r] <= '0;
    end else if (wr_en_s) begin
      mem_r[widx_s] <= merge_s;
    end
  end

  // Response pipeline: stage 0 captures the read, later stages add latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_r <= '0;
      pw_r <= '0;
      pe_r <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pd_r[i] <= '0;
      end
    end else begin
      pv_r[0] <= acc_s;
      pw_r[0] <= acc_s & req_write;
      pe_r[0] <= acc_s & err_s;
      pd_r[0] <= (acc_s & ~req_write & ~err_s) ? ext_s : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_r[i] <= pv_r[i-1];
        pw_r[i] <= pw_r[i-1];
        pe_r[i] <= pe_r[i-1];
        pd_r[i] <= pd_r[i-1];
      end
    end
  end

  assign req_ready  = ready_r;
  assign init_done  = done_r;
  assign resp_valid = pv_r[READ_LAT-1];
  assign resp_write = pw_r[READ_LAT-1];
  assign resp_err   = pe_r[READ_LAT-1];
  assign resp_rdata = pd_r[READ_LAT-1];

endmodule
